twf_mul_stream: RTL and testbench
=================================

TWF_MUL_STREAM -- requirements
Module: twf_mul_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 11, signed input sample width per component.
REQ-002 SHALL have parameter TWF_WIDTH, default 10, signed twiddle width.
REQ-003 SHALL have parameter FRAC, default 8, twiddle fraction bits; unity twiddle value = 2^FRAC.
REQ-004 SHALL have parameter DOUT_WIDTH, default WIDTH+TWF_WIDTH-FRAC (13), signed output width.
REQ-005 SHALL have parameter LANES, default 16, complex samples per beat.
REQ-006 SHALL have parameter NPT, default 8, twiddle table size; legal values 4 and 8; SW = log2(NPT).
REQ-007 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-009 SHALL have port mode, input, 1 bit: 0 = static twiddle, 1 = auto-sequenced twiddle.
REQ-010 SHALL have port twf_sel, input, SW bits, twiddle index k in static mode.
REQ-011 SHALL have port round_en, input, 1 bit: 1 = round-half-up, 0 = truncate (floor).
REQ-012 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_last (input, 1, final beat of frame).
REQ-013 SHALL have ports din_R and din_Q, input, LANES x WIDTH signed, real and imaginary samples.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1).
REQ-015 SHALL have ports dout_R and dout_Q, output, LANES x DOUT_WIDTH signed.

Function
REQ-016 SHALL use twiddle W^k = round(2^FRAC*cos(2*pi*k/NPT)) - j*round(2^FRAC*sin(2*pi*k/NPT)); for NPT=8, FRAC=8: R = {256,181,0,-181,-256,-181,0,181}, Q = {0,-181,-256,-181,0,181,256,181}.
REQ-017 SHALL accept a beat when in_valid && in_ready; mode, twf_sel, round_en and in_last are sampled with the beat and travel with it.
REQ-018 In static mode, all lanes of a beat SHALL use k = twf_sel.
REQ-019 In auto mode, lane i of beat b SHALL use k = (b * (i mod NPT)) mod NPT, where b is the internal beat counter.
REQ-020 Beat counter SHALL increment on every accepted beat, wrap NPT-1 -> 0, and return to 0 after an accepted beat with in_last=1; it SHALL count in both modes.
REQ-021 Per lane, the block SHALL compute P_R = a*c - b*d and P_Q = a*d + b*c at full precision, where a+jb is the sample and c+jd the twiddle.
REQ-022 Scaling SHALL be P >>> FRAC (arithmetic) when round_en=0, and (P + 2^(FRAC-1)) >>> FRAC when round_en=1; the result SHALL be placed in DOUT_WIDTH with no overflow possible for legal twiddles.
REQ-023 The pipeline SHALL have exactly 3 register stages: stage 1 registers input and twiddle, stage 2 registers products, stage 3 registers the sum/scale result; latency = 3 cycles with out_ready held at 1.
REQ-024 Pipeline enable SHALL be en = !out_valid || out_ready; in_ready = en; all stages hold while en=0.
REQ-025 While out_valid=1 and out_ready=0, dout_R, dout_Q and out_last SHALL stay stable.
REQ-026 out_last SHALL equal the in_last of the beat being output.
REQ-027 Sustained throughput with out_ready=1 SHALL be one beat per cycle.

Reset
REQ-028 When rst=1 at a clock edge, all stage valid bits, the beat counter, out_valid, out_last, dout_R and dout_Q SHALL be cleared to 0.
REQ-029 During reset, in_ready SHALL be 0; it SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-frame SHALL discard all in-flight beats, and the next accepted beat SHALL be b=0.

Verification
REQ-031 Static mode, k=2, din_R[i]=din_Q[i]=i, out_ready=1 -> 3 cycles later dout_R[i]=i, dout_Q[i]=-i.
REQ-032 Static mode, k=1, din_R=100, din_Q=0 -> round_en=1 gives dout_R=71, dout_Q=-71; round_en=0 gives dout_R=70, dout_Q=-71.
REQ-033 Auto mode, NPT=8, 8 beats of all lanes 64+j0 -> on beat 1, lane 2 uses k=2 and gives 0-j64; on beat 3, lane 3 uses k=1 and gives 45-j45 (rounded).
REQ-034 Stream 10 beats with out_ready toggled randomly -> no loss or duplication, order preserved, output stable while stalled.
REQ-035 in_last on beat 4 -> out_last on output beat 4 only; the next beat uses b=0.
REQ-036 Assert rst for one cycle with 2 beats in flight -> out_valid=0 next cycle, those beats never appear, and in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/twf_mul_stream.sv
// twf_mul_stream: streaming complex multiply by an NPT-point twiddle, LANES lanes per beat, 3-stage
// pipeline with valid/ready backpressure, static or auto-sequenced twiddle index per lane.
module twf_mul_stream #(
    parameter int WIDTH      = 11,
    parameter int TWF_WIDTH  = 10,
    parameter int FRAC       = 8,
    parameter int DOUT_WIDTH = WIDTH + TWF_WIDTH - FRAC,
    parameter int LANES      = 16,
    parameter int NPT        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [$clog2(NPT)-1:0]        twf_sel,
    input  logic                          round_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [LANES*WIDTH-1:0]        din_R,
    input  logic [LANES*WIDTH-1:0]        din_Q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [LANES*DOUT_WIDTH-1:0]   dout_R,
    output logic [LANES*DOUT_WIDTH-1:0]   dout_Q
);
    localparam int SW    = $clog2(NPT);
    localparam int MW    = WIDTH + TWF_WIDTH;
    localparam int PW    = MW + 1;
    localparam int UNITY = 1 << FRAC;
    localparam int HALF  = 1 << (FRAC - 1);
    // round(2^FRAC * sqrt(2)/2) from a 16-bit fixed-point constant
    localparam int C45   = int'((longint'(UNITY) * 46341 + 32768) >>> 16);
    localparam logic signed [TWF_WIDTH-1:0] TW_R [8] = '{
        TWF_WIDTH'(UNITY), TWF_WIDTH'(C45), TWF_WIDTH'(0), TWF_WIDTH'(-C45),
        TWF_WIDTH'(-UNITY), TWF_WIDTH'(-C45), TWF_WIDTH'(0), TWF_WIDTH'(C45)};
    localparam logic signed [TWF_WIDTH-1:0] TW_Q [8] = '{
        TWF_WIDTH'(0), TWF_WIDTH'(-C45), TWF_WIDTH'(-UNITY), TWF_WIDTH'(-C45),
        TWF_WIDTH'(0), TWF_WIDTH'(C45), TWF_WIDTH'(UNITY), TWF_WIDTH'(C45)};

    logic en, acc;
    logic [SW-1:0] bcnt;
    logic v1, v2, l1, l2, r1, r2;
    logic signed [WIDTH-1:0] a1 [LANES];
    logic signed [WIDTH-1:0] b1 [LANES];
    logic signed [TWF_WIDTH-1:0] c0 [LANES];
    logic signed [TWF_WIDTH-1:0] d0 [LANES];
    logic signed [TWF_WIDTH-1:0] c1 [LANES];
    logic signed [TWF_WIDTH-1:0] d1 [LANES];
    logic signed [MW-1:0] ac [LANES];
    logic signed [MW-1:0] bd [LANES];
    logic signed [MW-1:0] ad [LANES];
    logic signed [MW-1:0] bc [LANES];
    logic signed [DOUT_WIDTH-1:0] pr [LANES];
    logic signed [DOUT_WIDTH-1:0] pq [LANES];

    // A 4-point index k is the 8-point index 2k
    function automatic logic [2:0] tw_idx(input logic [SW-1:0] k);
        return 3'(int'(k) << (3 - SW));
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;
    assign acc      = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            c0[i] = TW_R[tw_idx(mode ? SW'(bcnt * SW'(i % NPT)) : twf_sel)];
            d0[i] = TW_Q[tw_idx(mode ? SW'(bcnt * SW'(i % NPT)) : twf_sel)];
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            pr[i] = DOUT_WIDTH'((PW'(ac[i]) - PW'(bd[i]) + (r2 ? PW'(HALF) : PW'(0))) >>> FRAC);
            pq[i] = DOUT_WIDTH'((PW'(ad[i]) + PW'(bc[i]) + (r2 ? PW'(HALF) : PW'(0))) >>> FRAC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dout_R    <= '0;
            dout_Q    <= '0;
        end else begin
            if (acc) bcnt <= in_last ? '0 : SW'(bcnt + 1'b1);
            if (en) begin
                v1        <= in_valid;
                l1        <= in_last;
                r1        <= round_en;
                v2        <= v1;
                l2        <= l1;
                r2        <= r1;
                out_valid <= v2;
                out_last  <= v2 && l2;
                for (int i = 0; i < LANES; i++) begin
                    a1[i] <= din_R[i*WIDTH +: WIDTH];
                    b1[i] <= din_Q[i*WIDTH +: WIDTH];
                    c1[i] <= c0[i];
                    d1[i] <= d0[i];
                    ac[i] <= MW'(a1[i]) * MW'(c1[i]);
                    bd[i] <= MW'(b1[i]) * MW'(d1[i]);
                    ad[i] <= MW'(a1[i]) * MW'(d1[i]);
                    bc[i] <= MW'(b1[i]) * MW'(c1[i]);
                    dout_R[i*DOUT_WIDTH +: DOUT_WIDTH] <= pr[i];
                    dout_Q[i*DOUT_WIDTH +: DOUT_WIDTH] <= pq[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_twf_mul_stream.sv
// tb_twf_mul_stream: scoreboard bench for twf_mul_stream with directed vectors and a monitor process.
module tb_twf_mul_stream;
    localparam int W  = 11;
    localparam int DW = 13;
    localparam int L  = 16;
    localparam int VW = L * DW;

    logic clk = 1'b0, rst = 1'b1, mode = 1'b0, round_en = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last;
    logic [2:0] twf_sel = '0;
    logic [L*W-1:0] din_R = '0, din_Q = '0;
    logic [VW-1:0] dout_R, dout_Q;

    twf_mul_stream dut (
        .clk(clk), .rst(rst), .mode(mode), .twf_sel(twf_sel), .round_en(round_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .din_R(din_R), .din_Q(din_Q),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .dout_R(dout_R), .dout_Q(dout_Q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] r;
        logic [VW-1:0] q;
        logic          last;
        int            t;
        bit            lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int n_cmp = 0, n_err = 0, cyc = 0, tb_b = 0, last_t = 0, t_first = 0;
    int va[L], vb[L], hr[L], hq[L];
    int tr[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
    int tq[8] = '{0, -181, -256, -181, 0, 181, 256, 181};
    int o64r[8] = '{64, 45, 0, -45, -64, -45, 0, 45};
    int o64q[8] = '{0, -45, -64, -45, 0, 45, 64, 45};
    bit hand = 0, lat_en = 0, rand_rdy = 0, stalled = 0;
    logic [VW-1:0] hold_r, hold_q;
    logic hold_l;

    function automatic int scale(input int p, input bit rnd);
        return (p + (rnd ? 128 : 0)) >>> 8;
    endfunction

    function automatic void chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1 if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (stalled) begin
            chk("stable_r", dout_R, hold_r);
            chk("stable_q", dout_Q, hold_q);
            chk("stable_last", VW'(out_last), VW'(hold_l));
        end
        stalled = out_valid && !out_ready && !rst;
        hold_r  = dout_R;
        hold_q  = dout_Q;
        hold_l  = out_last;
        if (out_valid && out_ready && !rst) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: output beat %h with empty scoreboard, expected none", dout_R);
            end else begin
                mon_e = sbq.pop_front();
                chk("dout_R", dout_R, mon_e.r);
                chk("dout_Q", dout_Q, mon_e.q);
                chk("out_last", VW'(out_last), VW'(mon_e.last));
                if (mon_e.lat) chk("latency", VW'(cyc - mon_e.t), VW'(3));
            end
        end
    end

    task automatic send(input bit m, input int sel, input bit rnd, input bit lst);
        exp_t e;
        int k;
        @(negedge clk);
        for (int i = 0; i < L; i++) begin
            din_R[i*W +: W] = W'(va[i]);
            din_Q[i*W +: W] = W'(vb[i]);
        end
        mode = m; twf_sel = 3'(sel); round_en = rnd; in_last = lst; in_valid = 1'b1;
        for (int n = 0; !in_ready; n++) begin
            if (n == 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: in_ready 0 after %0d cycles, expected 1", n);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        for (int i = 0; i < L; i++) begin
            k = m ? (tb_b * (i % 8)) % 8 : sel;
            e.r[i*DW +: DW] = DW'(hand ? hr[i] : scale(va[i] * tr[k] - vb[i] * tq[k], rnd));
            e.q[i*DW +: DW] = DW'(hand ? hq[i] : scale(va[i] * tq[k] + vb[i] * tr[k], rnd));
        end
        e.last = lst; e.t = cyc; e.lat = lat_en;
        last_t = cyc;
        sbq.push_back(e);
        tb_b = lst ? 0 : (tb_b + 1) % 8;
        @(posedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; rand_rdy = 0; out_ready = 1'b1;
        for (int n = 0; sbq.size() != 0; n++) begin
            if (n == 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sbq.size());
                sbq.delete();
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_dout_R", dout_R, VW'(0));
        chk("rst_dout_Q", dout_Q, VW'(0));
        chk("rst_in_ready", VW'(in_ready), VW'(0));
        rst = 1'b0;
        #1 chk("post_rst_in_ready", VW'(in_ready), VW'(1));

        // static k=2 on a ramp, then k=1 with rounding on and off
        hand = 1; lat_en = 1;
        for (int i = 0; i < L; i++) begin va[i] = i; vb[i] = i; hr[i] = i; hq[i] = -i; end
        send(0, 2, 0, 0);
        for (int i = 0; i < L; i++) begin va[i] = 100; vb[i] = 0; hr[i] = 71; hq[i] = -71; end
        send(0, 1, 1, 0);
        for (int i = 0; i < L; i++) begin hr[i] = 70; hq[i] = -71; end
        send(0, 1, 0, 1);
        for (int i = 0; i < L; i++) begin va[i] = -1024; vb[i] = -1024; hr[i] = 0; hq[i] = 1448; end
        send(0, 3, 0, 0);
        for (int i = 0; i < L; i++) begin va[i] = -1024; vb[i] = 1023; hr[i] = 1024; hq[i] = -1023; end
        send(0, 4, 0, 1);
        lat_en = 0;

        // auto mode, 64+j0, beats 1 and 3 against a hand table
        for (int i = 0; i < L; i++) begin va[i] = 64; vb[i] = 0; end
        for (int bt = 0; bt < 8; bt++) begin
            hand = (bt == 1 || bt == 3);
            for (int i = 0; i < L; i++) begin hr[i] = o64r[(bt * i) % 8]; hq[i] = o64q[(bt * i) % 8]; end
            send(1, 0, 1, 0);
            if (bt == 0) t_first = last_t;
        end
        chk("throughput_8_beats", VW'(last_t - t_first), VW'(7));
        hand = 0;

        // in_last on the 4th beat restarts the beat counter
        for (int bt = 0; bt < 6; bt++) begin
            for (int i = 0; i < L; i++) begin va[i] = 37 * i - 300 + 13 * bt; vb[i] = 200 - 23 * i + 5 * bt; end
            send(1, 0, bt[0], bt == 3);
        end
        drain();

        // random backpressure and random beats
        rand_rdy = 1;
        for (int bt = 0; bt < 10; bt++) begin
            for (int i = 0; i < L; i++) begin
                va[i] = int'($urandom_range(0, 2047)) - 1024;
                vb[i] = int'($urandom_range(0, 2047)) - 1024;
            end
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), bt == 9);
        end
        drain();

        // reset with two beats in flight
        for (int i = 0; i < L; i++) begin va[i] = 50 * i - 400; vb[i] = 300 - 40 * i; end
        send(1, 0, 0, 0);
        send(1, 0, 1, 0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", VW'(out_valid), VW'(0));
        chk("midrst_in_ready", VW'(in_ready), VW'(0));
        rst = 1'b0; sbq.delete(); tb_b = 0;
        #1 chk("midrst_in_ready_after", VW'(in_ready), VW'(1));
        repeat (4) begin
            @(negedge clk);
            chk("flushed_out_valid", VW'(out_valid), VW'(0));
        end
        hand = 1;
        for (int i = 0; i < L; i++) begin va[i] = 31 * i - 250; vb[i] = 90 - 17 * i; hr[i] = va[i]; hq[i] = vb[i]; end
        for (int i = 1; i < L; i += 2) begin va[i] = 5 * i; hr[i] = va[i]; end
        send(1, 5, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
